// File: rtl/memory_router_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : memory_router_if                                              |
// | Purpose  : Bundles the CPU-side, SRAM-side and LPDDR2-side signals of    |
// |            the memory router.                                            |
// |            modport master : the router (accepts CPU accesses, drives     |
// |                             the memory strobes)                          |
// |            modport slave  : the surroundings (CPU stage, SRAM and        |
// |                             external controller)                         |
// | Signals  : cpu_*  request/response with the CPU memory stage             |
// |            sram_* synchronous SRAM port                                  |
// |            ext_*  external LPDDR2 request/ack/read-data port             |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface memory_router_if #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int SRAM_AW = 12,
  parameter int EXT_AW  = 27
);
  localparam int BE_W = DATA_W / 8;

  // CPU side
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [BE_W-1:0]   cpu_be;
  logic              abort;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              cpu_err;
  logic              cpu_busy;

  // SRAM side
  logic [SRAM_AW-1:0] sram_addr;
  logic [DATA_W-1:0]  sram_wdata;
  logic [BE_W-1:0]    sram_be;
  logic               sram_we;
  logic [DATA_W-1:0]  sram_q;

  // External side
  logic [EXT_AW-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic [BE_W-1:0]   ext_be;
  logic              ext_read_req;
  logic              ext_write_req;
  logic              ext_ack;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_rvalid;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, abort,
    input  sram_q, ext_ack, ext_rdata, ext_rvalid,
    output cpu_rdata, cpu_ready, cpu_err, cpu_busy,
    output sram_addr, sram_wdata, sram_be, sram_we,
    output ext_addr, ext_wdata, ext_be, ext_read_req, ext_write_req
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, abort,
    output sram_q, ext_ack, ext_rdata, ext_rvalid,
    input  cpu_rdata, cpu_ready, cpu_err, cpu_busy,
    input  sram_addr, sram_wdata, sram_be, sram_we,
    input  ext_addr, ext_wdata, ext_be, ext_read_req, ext_write_req
  );
endinterface
`default_nettype wire

// File: rtl/memory_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : memory_router                                                 |
// | Purpose  : Decodes CPU word accesses to on-chip SRAM or the external     |
// |            LPDDR2 port, runs the external req/ack handshake with a       |
// |            timeout, and returns ready/err to the CPU. An abort cancels   |
// |            the pending response; outstanding external read beats are     |
// |            drained so no stale data reaches a later access.              |
// | Ports    : clk    clock                                                  |
// |            rst    asynchronous active-high reset                         |
// |            mem_if memory_router_if.master (CPU, SRAM and ext signals)    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module memory_router #(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int SRAM_AW = 12,
  parameter int EXT_AW  = 27,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  memory_router_if.master mem_if
);

  localparam int BE_W   = DATA_W / 8;
  localparam int CAP_AW = (SRAM_AW > EXT_AW) ? SRAM_AW : EXT_AW;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);
  // Counter value in the last cycle allowed before the timeout fires.
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SRAM_ACC = 3'd1,
    EXT_REQ  = 3'd2,
    EXT_RD   = 3'd3,
    RESP     = 3'd4,
    RESP_ERR = 3'd5,
    DRAIN    = 3'd6
  } state_t;

  state_t              state_q,    state_d;
  logic [CAP_AW-1:0]   addr_q,     addr_d;
  logic [DATA_W-1:0]   wdata_q,    wdata_d;
  logic [BE_W-1:0]     be_q,       be_d;
  logic                we_q,       we_d;
  logic                sram_sel_q, sram_sel_d;
  logic                err_pend_q, err_pend_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic [DATA_W-1:0]   rdata_q,    rdata_d;

  // Address decode. The offset wraps for SRAM addresses, but those are
  // already claimed by the SRAM compare so the wrapped value is unused.
  logic [ADDR_W-1:0] w_off;
  logic              w_hit_sram;
  logic              w_hit_ext;

  assign w_off      = mem_if.cpu_addr - ADDR_W'(64'd1 << SRAM_AW);
  assign w_hit_sram = 64'(mem_if.cpu_addr) < (64'd1 << SRAM_AW);
  assign w_hit_ext  = 64'(w_off) < (64'd1 << EXT_AW);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      we_q       <= 1'b0;
      sram_sel_q <= 1'b0;
      err_pend_q <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      sram_sel_q <= sram_sel_d;
      err_pend_q <= err_pend_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    sram_sel_d = sram_sel_q;
    err_pend_d = err_pend_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (mem_if.cpu_req && !mem_if.abort) begin
          // SRAM keeps its own word address; external accesses store the
          // offset into the external region.
          addr_d     = CAP_AW'(w_hit_sram ? mem_if.cpu_addr : w_off);
          wdata_d    = mem_if.cpu_wdata;
          be_d       = mem_if.cpu_be;
          we_d       = mem_if.cpu_we;
          sram_sel_d = w_hit_sram;
          err_pend_d = 1'b0;
          cnt_d      = '0;
          if (w_hit_sram)     state_d = SRAM_ACC;
          else if (w_hit_ext) state_d = EXT_REQ;
          else                state_d = RESP_ERR;
        end
      end

      SRAM_ACC: begin
        // A write strobe already on the bus this cycle commits even on abort.
        state_d = mem_if.abort ? IDLE : RESP;
      end

      EXT_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_if.ext_ack) begin
          // Ack beats timeout: the controller has taken the request.
          if (we_q) state_d = mem_if.abort ? IDLE  : RESP;
          else      state_d = mem_if.abort ? DRAIN : EXT_RD;
        end else if (mem_if.abort) begin
          state_d = IDLE;
        end else if (cnt_q == C_CNT_LAST) begin
          state_d = RESP_ERR;
        end
      end

      EXT_RD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_if.ext_rvalid) begin
          // Data arriving with abort is simply dropped; nothing is left to drain.
          if (mem_if.abort) begin
            state_d = IDLE;
          end else begin
            rdata_d = mem_if.ext_rdata;
            state_d = RESP;
          end
        end else if (mem_if.abort) begin
          state_d = DRAIN;
        end else if (cnt_q == C_CNT_LAST) begin
          err_pend_d = 1'b1;
          state_d    = DRAIN;
        end
      end

      DRAIN: begin
        // Counter holds here; the beat must still arrive before a new access.
        if (mem_if.ext_rvalid) begin
          state_d    = (err_pend_q && !mem_if.abort) ? RESP_ERR : IDLE;
          err_pend_d = 1'b0;
        end else if (mem_if.abort) begin
          err_pend_d = 1'b0;
        end
      end

      RESP: begin
        // sram_q becomes valid one cycle after the address, i.e. now.
        if (sram_sel_q && !we_q) rdata_d = mem_if.sram_q;
        state_d = IDLE;
      end

      RESP_ERR: begin
        rdata_d = '0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign mem_if.cpu_rdata     = rdata_q;
  assign mem_if.cpu_ready     = (state_q == RESP) || (state_q == RESP_ERR);
  assign mem_if.cpu_err       = (state_q == RESP_ERR);
  assign mem_if.cpu_busy      = (state_q != IDLE);

  assign mem_if.sram_addr     = addr_q[SRAM_AW-1:0];
  assign mem_if.sram_wdata    = wdata_q;
  assign mem_if.sram_be       = be_q;
  assign mem_if.sram_we       = (state_q == SRAM_ACC) && we_q;

  assign mem_if.ext_addr      = addr_q[EXT_AW-1:0];
  assign mem_if.ext_wdata     = wdata_q;
  assign mem_if.ext_be        = be_q;
  assign mem_if.ext_read_req  = (state_q == EXT_REQ) && !we_q;
  assign mem_if.ext_write_req = (state_q == EXT_REQ) && we_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_memory_router                                              |
// | Purpose  : Directed self-checking bench for memory_router: SRAM write/   |
// |            read, external read with ack/rvalid latency, timeout, abort   |
// |            with stale-beat drain, bad address, decode boundaries, abort  |
// |            priority in IDLE and asynchronous reset.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_memory_router;

  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

  memory_router_if #(.ADDR_W(30), .DATA_W(32), .SRAM_AW(12), .EXT_AW(27)) bus_if ();

  memory_router #(
    .ADDR_W(30), .DATA_W(32), .SRAM_AW(12), .EXT_AW(27), .TIMEOUT(255)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .mem_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous SRAM model: byte-enabled write, read data one clock later.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (bus_if.sram_we) begin
      for (int b = 0; b < 4; b++)
        if (bus_if.sram_be[b]) mem[bus_if.sram_addr][8*b +: 8] <= bus_if.sram_wdata[8*b +: 8];
    end
    bus_if.sram_q <= mem[bus_if.sram_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [29:0] addr, input logic [31:0] wd,
                       input logic [3:0] be);
    bus_if.cpu_req   = 1'b1;
    bus_if.cpu_we    = we;
    bus_if.cpu_addr  = addr;
    bus_if.cpu_wdata = wd;
    bus_if.cpu_be    = be;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus_if.cpu_req = 1'b0; bus_if.cpu_we = 1'b0; bus_if.cpu_addr = '0;
    bus_if.cpu_wdata = '0; bus_if.cpu_be = '0; bus_if.abort = 1'b0;
    bus_if.ext_ack = 1'b0; bus_if.ext_rdata = '0; bus_if.ext_rvalid = 1'b0;

    // ---- reset state
    step(); step();
    rst = 1'b0;
    chk("rst_busy",  bus_if.cpu_busy, 0);
    chk("rst_ready", bus_if.cpu_ready, 0);
    chk("rst_rdata", bus_if.cpu_rdata, 0);
    chk("rst_strobes", {bus_if.sram_we, bus_if.ext_read_req, bus_if.ext_write_req}, 0);

    // ---- SRAM write 0x005
    issue(1'b1, 30'h005, 32'hDEADBEEF, 4'hF);
    step(); bus_if.cpu_req = 1'b0;
    chk("sw_acc_we",   bus_if.sram_we, 1);
    chk("sw_acc_addr", bus_if.sram_addr, 12'h005);
    chk("sw_acc_rdy",  bus_if.cpu_ready, 0);
    chk("sw_acc_ext",  {bus_if.ext_read_req, bus_if.ext_write_req}, 0);
    step();
    chk("sw_resp", {bus_if.cpu_ready, bus_if.cpu_err, bus_if.sram_we}, 3'b100);
    step();
    chk("sw_idle", {bus_if.cpu_ready, bus_if.cpu_busy}, 2'b00);

    // ---- SRAM read 0x005
    issue(1'b0, 30'h005, 32'h0, 4'hF);
    step(); bus_if.cpu_req = 1'b0;
    chk("sr_acc", {bus_if.sram_we, bus_if.cpu_ready, bus_if.ext_read_req}, 3'b000);
    step();
    chk("sr_resp", {bus_if.cpu_ready, bus_if.cpu_err}, 2'b10);
    step();
    chk("sr_rdata", bus_if.cpu_rdata, 32'hDEADBEEF);

    // ---- EXT read 0x1010, ack on 3rd request cycle, rvalid after 4 cycles
    issue(1'b0, 30'h1010, 32'h0, 4'hF);
    step(); bus_if.cpu_req = 1'b0;
    chk("er_addr", bus_if.ext_addr, 27'h010);
    chk("er_req1", {bus_if.ext_read_req, bus_if.ext_write_req}, 2'b10);
    step();
    chk("er_req2", bus_if.ext_read_req, 1);
    step();
    chk("er_req3", bus_if.ext_read_req, 1);
    bus_if.ext_ack = 1'b1;
    step(); bus_if.ext_ack = 1'b0;
    chk("er_req_drop", bus_if.ext_read_req, 0);
    step(); step(); step();
    chk("er_wait_rdy", bus_if.cpu_ready, 0);
    bus_if.ext_rvalid = 1'b1; bus_if.ext_rdata = 32'hCAFEF00D;
    step(); bus_if.ext_rvalid = 1'b0;
    chk("er_resp", {bus_if.cpu_ready, bus_if.cpu_err}, 2'b10);
    chk("er_rdata", bus_if.cpu_rdata, 32'hCAFEF00D);
    step();
    chk("er_idle", bus_if.cpu_busy, 0);

    // ---- timeout on EXT write with no ack
    issue(1'b1, 30'h1000, 32'h12345678, 4'hF);
    step(); bus_if.cpu_req = 1'b0;
    n = 0;
    while (bus_if.ext_write_req && n < 300) begin
      n++;
      step();
    end
    chk("to_cycles", n, 255);
    chk("to_resp", {bus_if.cpu_ready, bus_if.cpu_err}, 2'b11);
    step();
    chk("to_rdata", bus_if.cpu_rdata, 0);
    chk("to_idle", {bus_if.cpu_ready, bus_if.cpu_busy}, 2'b00);

    // ---- abort in EXT_RD, stale beat drained
    issue(1'b0, 30'h1020, 32'h0, 4'hF);
    step(); bus_if.cpu_req = 1'b0; bus_if.ext_ack = 1'b1;
    step(); bus_if.ext_ack = 1'b0;
    step(); bus_if.abort = 1'b1;
    step(); bus_if.abort = 1'b0;
    chk("ab_drain", {bus_if.cpu_busy, bus_if.cpu_ready}, 2'b10);
    bus_if.ext_rvalid = 1'b1; bus_if.ext_rdata = 32'h1111;
    step(); bus_if.ext_rvalid = 1'b0;
    chk("ab_no_resp", {bus_if.cpu_busy, bus_if.cpu_ready}, 2'b00);
    chk("ab_stale_rdata", bus_if.cpu_rdata, 0);
    issue(1'b0, 30'h1030, 32'h0, 4'hF);
    step(); bus_if.cpu_req = 1'b0; bus_if.ext_ack = 1'b1;
    step(); bus_if.ext_ack = 1'b0; bus_if.ext_rvalid = 1'b1; bus_if.ext_rdata = 32'h2222;
    step(); bus_if.ext_rvalid = 1'b0;
    chk("ab_new_resp", {bus_if.cpu_ready, bus_if.cpu_err}, 2'b10);
    chk("ab_new_rdata", bus_if.cpu_rdata, 32'h2222);
    step();

    // ---- BAD address 2**12 + 2**27
    issue(1'b1, 30'h0800_1000, 32'hFFFF_FFFF, 4'hF);
    step(); bus_if.cpu_req = 1'b0;
    chk("bad_resp", {bus_if.cpu_ready, bus_if.cpu_err}, 2'b11);
    chk("bad_strobes", {bus_if.sram_we, bus_if.ext_read_req, bus_if.ext_write_req}, 0);
    step();
    chk("bad_rdata", bus_if.cpu_rdata, 0);
    chk("bad_idle", bus_if.cpu_busy, 0);

    // ---- last external word, then withdraw with abort before ack
    issue(1'b0, 30'h0800_0FFF, 32'h0, 4'hF);
    step(); bus_if.cpu_req = 1'b0;
    chk("lastext_addr", bus_if.ext_addr, 27'h7FF_FFFF);
    chk("lastext_req", bus_if.ext_read_req, 1);
    bus_if.abort = 1'b1;
    step(); bus_if.abort = 1'b0;
    chk("withdraw", {bus_if.cpu_busy, bus_if.cpu_ready, bus_if.ext_read_req}, 3'b000);

    // ---- last SRAM word with partial byte enables, then read back
    issue(1'b1, 30'h0FFF, 32'h5566_7788, 4'b0101);
    step(); bus_if.cpu_req = 1'b0;
    chk("lastsram_addr", {bus_if.sram_we, bus_if.sram_addr}, {1'b1, 12'hFFF});
    step(); step();
    issue(1'b0, 30'h0FFF, 32'h0, 4'hF);
    step(); bus_if.cpu_req = 1'b0;
    step(); step();
    chk("lastsram_bytes", {bus_if.cpu_rdata[23:16], bus_if.cpu_rdata[7:0]}, 16'h6688);

    // ---- abort wins over cpu_req in IDLE
    issue(1'b0, 30'h005, 32'h0, 4'hF);
    bus_if.abort = 1'b1;
    step(); bus_if.cpu_req = 1'b0; bus_if.abort = 1'b0;
    chk("abort_idle", bus_if.cpu_busy, 0);
    step();
    chk("abort_idle2", {bus_if.cpu_busy, bus_if.sram_we}, 2'b00);

    // ---- asynchronous reset during EXT_REQ
    issue(1'b1, 30'h1040, 32'hA5A5A5A5, 4'h3);
    step(); bus_if.cpu_req = 1'b0;
    chk("pre_rst", {bus_if.ext_write_req, bus_if.ext_be, bus_if.ext_wdata},
        {1'b1, 4'h3, 32'hA5A5A5A5});
    chk("pre_rst_rdata_nz", bus_if.cpu_rdata != 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ext", {bus_if.ext_write_req, bus_if.ext_read_req, bus_if.ext_be,
                     bus_if.ext_wdata, bus_if.ext_addr}, 0);
    chk("arst_cpu", {bus_if.cpu_busy, bus_if.cpu_ready, bus_if.cpu_err, bus_if.cpu_rdata}, 0);
    chk("arst_sram", {bus_if.sram_we, bus_if.sram_addr, bus_if.sram_be}, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst", bus_if.cpu_busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
